// File: rtl/rom_arbiter.sv
// Burst-read arbiter sharing one synchronous single-port ROM between PORTS requesters.
// Define ROM_ARB_PRIO_EN for fixed lowest-index-wins priority; round robin otherwise.
module rom_arbiter #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 4096,
    parameter  int unsigned PORTS = 2,
    parameter  int unsigned LEN_W = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PORTS-1:0]       req_stb,
    input  logic [PORTS*AW-1:0]    req_adr,
    input  logic [PORTS*LEN_W-1:0] req_len,
    output logic [PORTS-1:0]       req_ack,
    output logic [PORTS-1:0]       rsp_stb,
    input  logic [PORTS-1:0]       rsp_rdy,
    output logic [WIDTH-1:0]       rsp_dat,
    output logic                   rsp_lst,
    output logic                   rom_ren,
    output logic [AW-1:0]          rom_adr,
    input  logic [WIDTH-1:0]       rom_dat
);

    localparam int unsigned PW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int unsigned KW = PW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    adr_q, adr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    gnt_q, gnt_d;
    logic [PORTS-1:0] stb_q, stb_d;
    logic             lst_q, lst_d;

    logic             pick_vld;
    logic [PW-1:0]    pick_idx;
    logic             stall;
    logic             accept;

`ifndef ROM_ARB_PRIO_EN
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [KW-1:0]    scan;
`endif

    // Grantee search: first requesting port in priority order
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
`ifdef ROM_ARB_PRIO_EN
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (!pick_vld && req_stb[PW'(i)]) begin
                pick_vld = 1'b1;
                pick_idx = PW'(i);
            end
        end
`else
        scan = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            scan = {1'b0, ptr_q} + KW'(i);
            if (scan >= KW'(PORTS)) begin
                scan = scan - KW'(PORTS);
            end
            if (!pick_vld && req_stb[scan[PW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = scan[PW-1:0];
            end
        end
`endif
    end

    // Next-state and combinational handshake outputs
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        stb_d   = stb_q;
        lst_d   = lst_q;
`ifndef ROM_ARB_PRIO_EN
        ptr_d   = ptr_q;
`endif
        req_ack = '0;
        rom_ren = 1'b0;
        stall   = stb_q[gnt_q] & ~rsp_rdy[gnt_q];
        accept  = stb_q[gnt_q] &  rsp_rdy[gnt_q];

        case (state_q)
            S_IDLE: begin
                if (pick_vld && !rst) begin
                    req_ack[pick_idx] = 1'b1;
                    adr_d   = req_adr[pick_idx*AW +: AW];
                    cnt_d   = req_len[pick_idx*LEN_W +: LEN_W];
                    gnt_d   = pick_idx;
                    state_d = S_BURST;
`ifndef ROM_ARB_PRIO_EN
                    ptr_d   = (pick_idx == PW'(PORTS-1)) ? '0 : pick_idx + PW'(1);
`endif
                end
            end
            S_BURST: begin
                // A read may replace the presented beat only once it is taken
                if (!stall) begin
                    rom_ren = 1'b1;
                    adr_d   = (adr_q == AW'(DEPTH-1)) ? '0 : adr_q + AW'(1);
                    cnt_d   = cnt_q - LEN_W'(1);
                    lst_d   = (cnt_q == '0);
                    stb_d   = '0;
                    stb_d[gnt_q] = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = S_DRAIN;
                    end
                end else if (accept) begin
                    stb_d = '0;
                end
            end
            S_DRAIN: begin
                if (accept) begin
                    stb_d   = '0;
                    lst_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            stb_q   <= '0;
            lst_q   <= 1'b0;
`ifndef ROM_ARB_PRIO_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            stb_q   <= stb_d;
            lst_q   <= lst_d;
`ifndef ROM_ARB_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign rsp_stb = stb_q;
    assign rsp_lst = lst_q;
    assign rom_adr = adr_q;
    assign rsp_dat = rom_dat;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: vector table, directed corner sequences and random traffic
// checked against a transaction-level model (expected beat queue per granted burst).
module tb_rom_arbiter;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4096;
    localparam int unsigned PORTS = 2;
    localparam int unsigned LEN_W = 4;
    localparam int unsigned AW    = 12;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [PORTS-1:0]       req_stb;
    logic [PORTS*AW-1:0]    req_adr;
    logic [PORTS*LEN_W-1:0] req_len;
    logic [PORTS-1:0]       req_ack;
    logic [PORTS-1:0]       rsp_stb;
    logic [PORTS-1:0]       rsp_rdy;
    logic [WIDTH-1:0]       rsp_dat;
    logic                   rsp_lst;
    logic                   rom_ren;
    logic [AW-1:0]          rom_adr;
    logic [WIDTH-1:0]       rom_dat;

    rom_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(PORTS), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .req_stb(req_stb), .req_adr(req_adr), .req_len(req_len), .req_ack(req_ack),
        .rsp_stb(rsp_stb), .rsp_rdy(rsp_rdy), .rsp_dat(rsp_dat), .rsp_lst(rsp_lst),
        .rom_ren(rom_ren), .rom_adr(rom_adr), .rom_dat(rom_dat)
    );

    always #5 clk = ~clk;

    // ROM preloaded with mem[i] = i[7:0]; output holds while not read
    always @(posedge clk) begin
        if (rom_ren) rom_dat <= rom_adr[7:0];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Values sampled on the falling edge
    int               s_cyc;
    logic [PORTS-1:0] s_ack, s_stb, s_rdy;
    logic             s_ren, s_lst, s_rst;
    logic [WIDTH-1:0] s_dat;
    logic [AW-1:0]    s_adr;

    // Reference model state
    bit m_busy = 0;
    int m_gp, m_start, m_left, m_issued, m_accepted;
    int m_ptr = 0;
    int q_dat[$];
    bit q_lst[$];

    typedef struct {
        int port;
        int adr;
        int len;
        int exp_first;
        int exp_last;
        int exp_beats;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_req(input int p, input bit v, input int adr, input int len);
        req_stb[p]                = v;
        req_adr[p*AW +: AW]       = AW'(adr);
        req_len[p*LEN_W +: LEN_W] = LEN_W'(len);
    endtask

    task automatic model_check();
        int pend, e, base, idx, len;
        bit stall, exp_ren, lst;
        if (s_rst) begin
            chk("rst_req_ack", int'(s_ack), 0);
            chk("rst_rsp_stb", int'(s_stb), 0);
            chk("rst_rom_ren", int'(s_ren), 0);
            chk("rst_rom_adr", int'(s_adr), 0);
            chk("rst_rsp_lst", int'(s_lst), 0);
            m_busy = 0;
            m_ptr  = 0;
            q_dat.delete();
            q_lst.delete();
            return;
        end
        if (m_busy) begin
            pend = m_issued - m_accepted;
            chk("rsp_stb", int'(s_stb), (pend > 0) ? (1 << m_gp) : 0);
            chk("ack_while_busy", int'(s_ack), 0);
            stall   = (pend > 0) && !s_rdy[m_gp];
            exp_ren = (m_left > 0) && !stall;
            chk("rom_ren", int'(s_ren), int'(exp_ren));
            if (exp_ren) begin
                chk("rom_adr", int'(s_adr), (m_start + m_issued) % DEPTH);
                m_issued++;
                m_left--;
            end
            if (pend > 0 && s_stb[m_gp] && s_rdy[m_gp] && q_dat.size() > 0) begin
                chk("rsp_dat", int'(s_dat), q_dat.pop_front());
                lst = q_lst.pop_front();
                chk("rsp_lst", int'(s_lst), int'(lst));
                m_accepted++;
                if (lst) m_busy = 0;
            end
        end else begin
            chk("idle_rsp_stb", int'(s_stb), 0);
            chk("idle_rom_ren", int'(s_ren), 0);
`ifdef ROM_ARB_PRIO_EN
            base = 0;
`else
            base = m_ptr;
`endif
            e = -1;
            for (int k = 0; k < PORTS; k++) begin
                idx = (base + k) % PORTS;
                if (e < 0 && req_stb[idx]) e = idx;
            end
            chk("req_ack", int'(s_ack), (e >= 0) ? (1 << e) : 0);
            if (e >= 0) begin
                m_busy     = 1;
                m_gp       = e;
                m_start    = int'(req_adr[e*AW +: AW]);
                len        = int'(req_len[e*LEN_W +: LEN_W]);
                m_left     = len + 1;
                m_issued   = 0;
                m_accepted = 0;
                m_ptr      = (e + 1) % PORTS;
                for (int n = 0; n <= len; n++) begin
                    q_dat.push_back(((m_start + n) % DEPTH) & 255);
                    q_lst.push_back(n == len);
                end
            end
        end
    endtask

    // One clock: sample and check on the falling edge, return just after the rising edge
    task automatic step();
        @(negedge clk);
        s_cyc = cyc;
        s_ack = req_ack;
        s_stb = rsp_stb;
        s_rdy = rsp_rdy;
        s_ren = rom_ren;
        s_lst = rsp_lst;
        s_rst = rst;
        s_dat = rsp_dat;
        s_adr = rom_adr;
        model_check();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        req_stb = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain_idle();
        req_stb = '0;
        rsp_rdy = '1;
        for (int t = 0; t < 100 && m_busy; t++) step();
        chk("drain_timeout", int'(m_busy), 0);
        step();
    endtask

    task automatic run_burst(input int p, input int adr, input int len,
                             output int first_dat, output int last_dat,
                             output int beats, output int lat, output int span);
        int ack_c, first_c, last_c;
        bit done;
        ack_c = -1; first_c = -1; last_c = -1; done = 0;
        beats = 0; first_dat = -1; last_dat = -1;
        set_req(p, 1, adr, len);
        rsp_rdy = '1;
        for (int t = 0; t < 60 && !done; t++) begin
            step();
            if (s_ack[p] && ack_c < 0) begin
                ack_c      = s_cyc;
                req_stb[p] = 1'b0;
            end
            if (s_stb[p] && s_rdy[p]) begin
                if (beats == 0) begin
                    first_c   = s_cyc;
                    first_dat = int'(s_dat);
                end
                beats++;
                last_dat = int'(s_dat);
                if (s_lst) begin
                    last_c = s_cyc;
                    done   = 1;
                end
            end
        end
        chk("burst_timeout", int'(done), 1);
        req_stb[p] = 1'b0;
        lat  = first_c - ack_c;
        span = last_c - first_c;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd, ld, nb, lat, span, beats, grants, g, p1_acks, ren_cnt;
        bit done, stalled, hit;

        vecs[0] = '{0, 'h010,  0, 'h10, 'h10,  1};
        vecs[1] = '{1, 'hFFE,  3, 'hFE, 'h01,  4};
        vecs[2] = '{0, 'h0FF,  7, 'hFF, 'h06,  8};
        vecs[3] = '{1, 'h7F0, 15, 'hF0, 'hFF, 16};
        vecs[4] = '{0, 'hFFF,  1, 'hFF, 'h00,  2};

        rst     = 1'b1;
        req_stb = '0;
        req_adr = '0;
        req_len = '0;
        rsp_rdy = '0;
        step();
        step();
        rst = 1'b0;
        step();

        // Single bursts: data, wrap, last flag, latency and back-to-back beats
        for (int i = 0; i < 5; i++) begin
            run_burst(vecs[i].port, vecs[i].adr, vecs[i].len, fd, ld, nb, lat, span);
            chk("vec_first_dat", fd, vecs[i].exp_first);
            chk("vec_last_dat", ld, vecs[i].exp_last);
            chk("vec_beats", nb, vecs[i].exp_beats);
            chk("vec_ack_to_first", lat, 2);
            chk("vec_first_to_last", span, vecs[i].len);
            step();
        end

        // Backpressure for three cycles after the second beat
        set_req(0, 1, 'h020, 7);
        rsp_rdy = '1;
        beats = 0; done = 0; stalled = 0; ld = -1;
        for (int t = 0; t < 60 && !done; t++) begin
            step();
            if (s_ack[0]) req_stb[0] = 1'b0;
            if (s_stb[0] && s_rdy[0]) begin
                beats++;
                ld = int'(s_dat);
                if (s_lst) done = 1;
            end
            if (beats == 2 && !stalled) begin
                stalled    = 1;
                rsp_rdy[0] = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    step();
                    chk("stall_rom_ren", int'(s_ren), 0);
                    chk("stall_rsp_dat", int'(s_dat), 'h22);
                    chk("stall_rsp_stb", int'(s_stb), 1);
                end
                rsp_rdy[0] = 1'b1;
            end
        end
        chk("stall_beats", beats, 8);
        chk("stall_last_dat", ld, 'h27);
        drain_idle();

        // Both ports requesting continuously
        do_reset();
        set_req(0, 1, 'h100, 0);
        set_req(1, 1, 'h200, 0);
        rsp_rdy = '1;
        grants = 0;
        for (int t = 0; t < 60 && grants < 6; t++) begin
            step();
            if (s_ack != '0) begin
                g = s_ack[1] ? 1 : 0;
`ifdef ROM_ARB_PRIO_EN
                chk("arb_grant", g, 0);
`else
                chk("arb_grant", g, grants % 2);
`endif
                grants++;
            end
        end
        chk("arb_grant_count", grants, 6);
        drain_idle();

        // Reset in the middle of a burst
        set_req(0, 1, 'h100, 7);
        rsp_rdy = '1;
        hit = 0;
        for (int t = 0; t < 40 && !hit; t++) begin
            step();
            if (s_ack[0]) req_stb[0] = 1'b0;
            if (s_stb[0] && s_rdy[0] && s_dat == 8'h02) hit = 1;
        end
        chk("rst_mid_reached", int'(hit), 1);
        chk("rst_mid_beat3_dat", int'(rsp_dat), 'h03);
        chk("rst_mid_beat3_stb", int'(rsp_stb), 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_rsp_stb", int'(rsp_stb), 0);
        chk("rst_mid_rom_ren", int'(rom_ren), 0);
        step();
        step();
        rst = 1'b0;
        set_req(0, 1, 'h040, 1);
        set_req(1, 1, 'h080, 1);
        hit = 0;
        for (int t = 0; t < 20 && !hit; t++) begin
            step();
            if (s_ack != '0) begin
                chk("post_reset_first_ack", int'(s_ack), 1);
                hit = 1;
            end
        end
        chk("post_reset_ack_seen", int'(hit), 1);
        req_stb[0] = 1'b0;
        for (int t = 0; t < 40 && req_stb[1]; t++) begin
            step();
            if (s_ack[1]) req_stb[1] = 1'b0;
        end
        drain_idle();

        // Port 1 withdraws its request while port 0 is bursting
        set_req(0, 1, 'h300, 7);
        rsp_rdy = '1;
        p1_acks = 0; ren_cnt = 0;
        for (int t = 0; t < 60; t++) begin
            step();
            if (s_ren) ren_cnt++;
            if (s_ack[1]) p1_acks++;
            if (s_ack[0]) req_stb[0] = 1'b0;
            if (t == 2) set_req(1, 1, 'h500, 3);
            if (t == 4) req_stb[1] = 1'b0;
            if (t > 4 && !m_busy) break;
        end
        for (int t = 0; t < 4; t++) begin
            step();
            if (s_ren) ren_cnt++;
            if (s_ack[1]) p1_acks++;
        end
        chk("withdrawn_acks", p1_acks, 0);
        chk("withdrawn_reads", ren_cnt, 8);

        // Random traffic with random backpressure
        for (int t = 0; t < 3000; t++) begin
            step();
            for (int p = 0; p < PORTS; p++) begin
                if (req_stb[p]) begin
                    if (s_ack[p]) req_stb[p] = 1'b0;
                    else if ($urandom_range(31) == 0) req_stb[p] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    set_req(p, 1, int'($urandom_range(DEPTH-1)), int'($urandom_range(15)));
                end
                rsp_rdy[p] = ($urandom_range(3) != 0);
            end
        end
        drain_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
